// File: rtl/rxd_ext.sv
// Parametrised UART receiver: two-flop synchroniser, oversampled 3-sample majority vote,
// configurable data width, parity and stop bits, with per-frame parity/framing/break status.
module rxd_ext #(
  parameter int SCYCLE     = 50_000_000,
  parameter int BAUDRATE   = 9600,
  parameter int DATABITS   = 8,
  parameter int PARITY     = 0,
  parameter int STOPBITS   = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                RX,
  output logic [DATABITS-1:0] RXDATA,
  output logic                RXVALID,
  output logic                RXBUSY,
  output logic                PERR,
  output logic                FERR,
  output logic                BREAKDET
);

  localparam int DIV_RAW = SCYCLE / (BAUDRATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW > 0) ? DIV_RAW : 1;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW      = $clog2(OVERSAMPLE);
  localparam int M       = OVERSAMPLE / 2;

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [TW-1:0] T_SAMP0   = TW'(M - 2);
  localparam logic [TW-1:0] T_SAMP1   = TW'(M - 1);
  localparam logic [TW-1:0] T_VOTE    = TW'(M);
  localparam logic [TW-1:0] T_LAST    = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATABITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOPBITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_WAITIDLE
  } state_t;

  state_t              state_q, state_d;
  logic                rx_meta_q, rx_meta_d;
  logic                rxs_q, rxs_d;
  logic                rxs_prev_q, rxs_prev_d;
  logic [DW-1:0]       div_cnt_q, div_cnt_d;
  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [1:0]          samp_q, samp_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [DATABITS-1:0] shift_q, shift_d;
  logic                par_q, par_d;
  logic                ferr_acc_q, ferr_acc_d;
  logic                ones_acc_q, ones_acc_d;
  logic [DATABITS-1:0] rxdata_q, rxdata_d;
  logic                rxvalid_q, rxvalid_d;
  logic                rxbusy_q, rxbusy_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic                breakdet_q, breakdet_d;

  logic fall, tick, vote, vote_tick, bit_end;
  logic parity_x, ferr_now, ones_now;

  // NOTE: every _d starts from its _q (or a fixed value) before any branch, so no latch is inferred.
  always_comb begin
    fall      = rxs_prev_q & ~rxs_q;
    tick      = (div_cnt_q == DIV_LAST);
    vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);
    vote_tick = tick && (tick_cnt_q == T_VOTE);
    bit_end   = tick && (tick_cnt_q == T_LAST);
    parity_x  = (^shift_q) ^ par_q;
    ferr_now  = ferr_acc_q | ~vote;
    ones_now  = ones_acc_q | vote;

    state_d    = state_q;
    rx_meta_d  = RX;
    rxs_d      = rx_meta_q;
    rxs_prev_d = rxs_q;
    samp_d     = samp_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    ferr_acc_d = ferr_acc_q;
    ones_acc_d = ones_acc_q;
    rxdata_d   = rxdata_q;
    rxvalid_d  = 1'b0;
    rxbusy_d   = rxbusy_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    breakdet_d = breakdet_q;

    if (tick) begin
      div_cnt_d  = '0;
      tick_cnt_d = (tick_cnt_q == T_LAST) ? '0 : tick_cnt_q + 1'b1;
    end else begin
      div_cnt_d  = div_cnt_q + 1'b1;
      tick_cnt_d = tick_cnt_q;
    end
    if (tick && (tick_cnt_q == T_SAMP0)) samp_d[0] = rxs_q;
    if (tick && (tick_cnt_q == T_SAMP1)) samp_d[1] = rxs_q;

    unique case (state_q)
      S_IDLE: begin
        rxbusy_d = 1'b0;
        if (fall) begin
          // Re-phase the bit timing to the detected start edge.
          state_d    = S_START;
          rxbusy_d   = 1'b1;
          div_cnt_d  = '0;
          tick_cnt_d = '0;
          ferr_acc_d = 1'b0;
          ones_acc_d = 1'b0;
        end
      end
      S_START: begin
        if (vote_tick && vote) begin
          state_d  = S_IDLE;
          rxbusy_d = 1'b0;
        end else if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (vote_tick) begin
          shift_d    = {vote, shift_q[DATABITS-1:1]};
          ones_acc_d = ones_now;
        end else if (bit_end) begin
          if (bit_cnt_q == DATA_LAST) begin
            state_d   = (PARITY != 0) ? S_PAR : S_STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PAR: begin
        if (vote_tick) begin
          par_d      = vote;
          ones_acc_d = ones_now;
        end else if (bit_end) begin
          state_d   = S_STOP;
          bit_cnt_d = '0;
        end
      end
      S_STOP: begin
        if (vote_tick) begin
          ferr_acc_d = ferr_now;
          ones_acc_d = ones_now;
          // The frame completes at the vote of the last stop bit, not at its end.
          if (bit_cnt_q == STOP_LAST) begin
            rxvalid_d  = 1'b1;
            rxdata_d   = shift_q;
            perr_d     = (PARITY == 0) ? 1'b0 : ((PARITY == 2) ? parity_x : ~parity_x);
            ferr_d     = ferr_now;
            breakdet_d = ~ones_now;
            state_d    = ferr_now ? S_WAITIDLE : S_IDLE;
          end
        end else if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_WAITIDLE: begin
        rxbusy_d = 1'b0;
        if (rxs_q) state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        rxbusy_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; all next-state math lives above.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      div_cnt_q  <= '0;
      tick_cnt_q <= '0;
      samp_q     <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      ferr_acc_q <= 1'b0;
      ones_acc_q <= 1'b0;
      rxdata_q   <= '0;
      rxvalid_q  <= 1'b0;
      rxbusy_q   <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      breakdet_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx_meta_d;
      rxs_q      <= rxs_d;
      rxs_prev_q <= rxs_prev_d;
      div_cnt_q  <= div_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      samp_q     <= samp_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      ferr_acc_q <= ferr_acc_d;
      ones_acc_q <= ones_acc_d;
      rxdata_q   <= rxdata_d;
      rxvalid_q  <= rxvalid_d;
      rxbusy_q   <= rxbusy_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      breakdet_q <= breakdet_d;
    end
  end

  assign RXDATA   = rxdata_q;
  assign RXVALID  = rxvalid_q;
  assign RXBUSY   = rxbusy_q;
  assign PERR     = perr_q;
  assign FERR     = ferr_q;
  assign BREAKDET = breakdet_q;

endmodule
